// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the frame-buffer arbiter
// Contents: FSM state enum, buffer index type, triple-buffer selection, saturating increment.
package fb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
  typedef logic [1:0] buf_idx_t;
  // First buffer of 0..2 that is neither being displayed nor just completed.
  function automatic buf_idx_t next_wr_buf(buf_idx_t rd, buf_idx_t done);
    return (rd != 2'd0 && done != 2'd0) ? 2'd0 : (rd != 2'd1 && done != 2'd1) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return v + 16'(v != 16'hffff);
  endfunction
endpackage

// File: rtl/fb_buf_arbiter_if.sv
// fb_buf_arbiter_if: burst command channel between arbiter (master) and SDRAM controller (slave)
// Signals: cmd_valid/cmd_ready handshake, cmd_write/cmd_addr/cmd_len fields, cmd_done completion pulse.
interface fb_buf_arbiter_if #(parameter int ADDR_W = 24, parameter int LEN_W = 10);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_done;
  modport master(output cmd_valid, cmd_write, cmd_addr, cmd_len, input cmd_ready, cmd_done);
  modport slave(input cmd_valid, cmd_write, cmd_addr, cmd_len, output cmd_ready, cmd_done);
endinterface

// File: rtl/fb_buf_arbiter_side.sv
// fb_side_ctr: per-side frame offset counter with remaining-burst length and eligibility
// Ports: clk, rst; start restarts the frame; adv advances off by len; avail is FIFO level/room;
// off/active state, rem = next burst length, elig = burst can issue, cmpl = this advance ends the frame.
module fb_side_ctr #(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 10,
  parameter int BURST_LEN  = 512,
  parameter int FRAME_SIZE = 1024000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W:0]    avail,
  output logic [ADDR_W-1:0] off,
  output logic              active,
  output logic [LEN_W-1:0]  rem,
  output logic              elig,
  output logic              cmpl
);
  localparam logic [ADDR_W-1:0] FS = ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] BL = ADDR_W'(BURST_LEN);
  logic [ADDR_W-1:0] left, nxt;
  always_comb begin
    left = FS - off;
    rem  = LEN_W'(left > BL ? BL : left);
    nxt  = off + ADDR_W'(len);
    cmpl = adv && !start && nxt >= FS;
    elig = active && avail >= {1'b0, rem};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      off    <= '0;
      active <= 1'b0;
    end else if (start) begin
      off    <= '0;
      active <= 1'b1;
    end else if (adv) begin
      off <= nxt;
      if (cmpl) active <= 1'b0;
    end
  end
endmodule

// File: rtl/fb_buf_arbiter.sv
// fb_buf_arbiter: frame-buffer manager and round-robin SDRAM burst arbiter (camera write / HDMI read)
// Ports: clk, rst; wr/rd_frame_start pulses; wr_fifo_level, rd_fifo_room; bus (command channel master);
// wr_buf_idx, rd_buf_idx, rd_frame_valid, drop_cnt, abort_cnt status outputs.
module fb_buf_arbiter
  import fb_pkg::*;
#(
  parameter int              ADDR_W     = 24,
  parameter int              LEN_W      = 10,
  parameter int              BURST_LEN  = 512,
  parameter int              FRAME_SIZE = 1024000,
  parameter int              NUM_BUF    = 3,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_frame_start,
  input  logic                  rd_frame_start,
  input  logic [LEN_W:0]        wr_fifo_level,
  input  logic [LEN_W:0]        rd_fifo_room,
  fb_buf_arbiter_if.master      bus,
  output buf_idx_t              wr_buf_idx,
  output buf_idx_t              rd_buf_idx,
  output logic                  rd_frame_valid,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           abort_cnt
);
  state_t            state, state_n;
  buf_idx_t          latest;
  logic              new_valid, stale;
  logic              load, accept, fin, gnt_wr, rd_go, bypass, wr_adv, rd_adv;
  logic [ADDR_W-1:0] wr_off, rd_off;
  logic [LEN_W-1:0]  wr_rem, rd_rem;
  logic              wr_active, rd_active, wr_elig, rd_elig, wr_cmpl, rd_cmpl;
  fb_side_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN), .FRAME_SIZE(FRAME_SIZE)) u_wr (
    .clk(clk), .rst(rst), .start(wr_frame_start), .adv(wr_adv), .len(bus.cmd_len), .avail(wr_fifo_level),
    .off(wr_off), .active(wr_active), .rem(wr_rem), .elig(wr_elig), .cmpl(wr_cmpl)
  );
  fb_side_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN), .FRAME_SIZE(FRAME_SIZE)) u_rd (
    .clk(clk), .rst(rst), .start(rd_go), .adv(rd_adv), .len(bus.cmd_len), .avail(rd_fifo_room),
    .off(rd_off), .active(rd_active), .rem(rd_rem), .elig(rd_elig), .cmpl(rd_cmpl)
  );
  // A reader start coinciding with write completion can use the new frame even if none existed before.
  assign rd_go         = rd_frame_start && (rd_frame_valid || wr_cmpl);
  assign bypass        = rd_frame_start && wr_cmpl;
  assign bus.cmd_valid = state == CMD;
  // cmd_write only changes on a grant, so it doubles as the last-granted side for round-robin.
  always_comb begin
    gnt_wr  = wr_elig && (!rd_elig || !bus.cmd_write);
    load    = state == IDLE && (wr_elig || rd_elig);
    accept  = state == CMD && bus.cmd_ready;
    fin     = state == WAIT && bus.cmd_done;
    state_n = load ? CMD : accept ? WAIT : fin ? IDLE : state;
    wr_adv  = fin && bus.cmd_write && !stale;
    rd_adv  = fin && !bus.cmd_write && !stale;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // stale marks a burst whose side restarted its frame after the grant; its offset advance is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_write <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_len   <= '0;
      stale         <= 1'b0;
    end else begin
      if (load) begin
        bus.cmd_write <= gnt_wr;
        bus.cmd_addr  <= gnt_wr ? ADDR_W'(wr_buf_idx) * BUF_STRIDE + wr_off
                                : ADDR_W'(rd_buf_idx) * BUF_STRIDE + rd_off;
        bus.cmd_len   <= gnt_wr ? wr_rem : rd_rem;
      end
      stale <= load ? (gnt_wr ? wr_frame_start : rd_go)
                    : stale || (bus.cmd_write ? wr_frame_start : rd_go);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf_idx     <= '0;
      rd_buf_idx     <= '0;
      latest         <= '0;
      new_valid      <= 1'b0;
      rd_frame_valid <= 1'b0;
      drop_cnt       <= '0;
      abort_cnt      <= '0;
    end else begin
      if (wr_frame_start && wr_active) abort_cnt <= sat_inc(abort_cnt);
      if (wr_cmpl) begin
        latest         <= wr_buf_idx;
        rd_frame_valid <= 1'b1;
        wr_buf_idx     <= NUM_BUF == 2 ? wr_buf_idx ^ 2'd1
                                       : next_wr_buf(bypass ? wr_buf_idx : rd_buf_idx, wr_buf_idx);
        if (new_valid && !bypass) drop_cnt <= sat_inc(drop_cnt);
      end
      if (bypass) rd_buf_idx <= wr_buf_idx;
      else if (rd_go && new_valid) rd_buf_idx <= latest;
      new_valid <= wr_cmpl ? !bypass : rd_go ? 1'b0 : new_valid;
    end
  end
endmodule

// File: tb/tb_fb_buf_arbiter.sv
// tb_fb_buf_arbiter: scoreboard bench for fb_buf_arbiter (FRAME_SIZE=1300, BURST_LEN=512, NUM_BUF=3)
module tb_fb_buf_arbiter;
  typedef struct packed {
    logic        w;
    logic [23:0] a;
    logic [9:0]  l;
  } exp_t;
  logic        clk, rst, wr_frame_start, rd_frame_start;
  logic [10:0] wr_fifo_level, rd_fifo_room;
  logic [1:0]  wr_buf_idx, rd_buf_idx;
  logic        rd_frame_valid;
  logic [15:0] drop_cnt, abort_cnt;
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  fb_buf_arbiter_if #(.ADDR_W(24), .LEN_W(10)) bus ();
  fb_buf_arbiter #(
    .ADDR_W(24), .LEN_W(10), .BURST_LEN(512), .FRAME_SIZE(1300), .NUM_BUF(3), .BUF_STRIDE(24'h100000)
  ) dut (
    .clk(clk), .rst(rst), .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_room(rd_fifo_room), .bus(bus),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx), .rd_frame_valid(rd_frame_valid),
    .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic w, input logic [23:0] a, input logic [9:0] l);
    sb.push_back('{w: w, a: a, l: l});
  endtask
  task automatic pulse(input logic w, input logic r);
    @(negedge clk);
    wr_frame_start = w;
    rd_frame_start = r;
    @(negedge clk);
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
  endtask
  task automatic get_cmd(output bit ok, output exp_t e);
    int t = 0;
    ok = 1'b0;
    e  = '0;
    while (!bus.cmd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_valid) chk("cmd_timeout", 32'd0, 32'd1);
    else if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
    else begin
      ok = 1'b1;
      e  = sb.pop_front();
      chk("cmd_write", 32'(bus.cmd_write), 32'(e.w));
      chk("cmd_addr", 32'(bus.cmd_addr), 32'(e.a));
      chk("cmd_len", 32'(bus.cmd_len), 32'(e.l));
    end
  endtask
  task automatic serve(input int stall, input logic rd_pulse);
    bit   ok;
    exp_t e;
    get_cmd(ok, e);
    if (ok) begin
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", 32'(bus.cmd_valid), 32'd1);
        chk("stall_addr", 32'(bus.cmd_addr), 32'(e.a));
        chk("stall_len", 32'(bus.cmd_len), 32'(e.l));
      end
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      chk("accept_valid_low", 32'(bus.cmd_valid), 32'd0);
      @(negedge clk);
      bus.cmd_done   = 1'b1;
      rd_frame_start = rd_pulse;
      @(negedge clk);
      bus.cmd_done   = 1'b0;
      rd_frame_start = 1'b0;
    end
  endtask
  task automatic chk_status(input string tag, input logic [1:0] w, input logic [1:0] r, input logic v,
                            input logic [15:0] d, input logic [15:0] a);
    chk({tag, "_wr_buf"}, 32'(wr_buf_idx), 32'(w));
    chk({tag, "_rd_buf"}, 32'(rd_buf_idx), 32'(r));
    chk({tag, "_frame_valid"}, 32'(rd_frame_valid), 32'(v));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(d));
    chk({tag, "_abort"}, 32'(abort_cnt), 32'(a));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit   ok;
    exp_t e;
    rst = 1'b1;
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
    wr_fifo_level = '0;
    rd_fifo_room = '0;
    bus.cmd_ready = 1'b0;
    bus.cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_write", 32'(bus.cmd_write), 32'd0);
    chk("rst_addr", 32'(bus.cmd_addr), 32'd0);
    chk("rst_len", 32'(bus.cmd_len), 32'd0);
    chk_status("rst", 2'd0, 2'd0, 1'b0, 16'd0, 16'd0);
    rst = 1'b0;
    // single frame into buffer 0, second burst stalled 20 cycles
    wr_fifo_level = 11'd512;
    pulse(1'b1, 1'b0);
    push(1'b1, 24'h000000, 10'd512);
    push(1'b1, 24'h000200, 10'd512);
    push(1'b1, 24'h000400, 10'd276);
    serve(0, 1'b0);
    serve(20, 1'b0);
    serve(0, 1'b0);
    chk_status("single", 2'd1, 2'd0, 1'b1, 16'd0, 16'd0);
    // contention: last grant was a write, so the read side wins the first tie
    rd_fifo_room = 11'd512;
    pulse(1'b1, 1'b1);
    push(1'b0, 24'h000000, 10'd512);
    push(1'b1, 24'h100000, 10'd512);
    push(1'b0, 24'h000200, 10'd512);
    push(1'b1, 24'h100200, 10'd512);
    push(1'b0, 24'h000400, 10'd276);
    push(1'b1, 24'h100400, 10'd276);
    repeat (6) serve(0, 1'b0);
    chk_status("contend", 2'd2, 2'd0, 1'b1, 16'd0, 16'd0);
    // overwrite: second undisplayed frame completes
    rd_fifo_room = '0;
    pulse(1'b1, 1'b0);
    push(1'b1, 24'h200000, 10'd512);
    push(1'b1, 24'h200200, 10'd512);
    push(1'b1, 24'h200400, 10'd276);
    repeat (3) serve(0, 1'b0);
    chk_status("overwrite", 2'd1, 2'd0, 1'b1, 16'd1, 16'd0);
    pulse(1'b0, 1'b1);
    chk("overwrite_rd_sel", 32'(rd_buf_idx), 32'd2);
    // abort at wr_off=512, frame restarts in the same buffer
    pulse(1'b1, 1'b0);
    push(1'b1, 24'h100000, 10'd512);
    serve(0, 1'b0);
    wr_fifo_level = '0;
    pulse(1'b1, 1'b0);
    chk_status("abort", 2'd1, 2'd2, 1'b1, 16'd1, 16'd1);
    wr_fifo_level = 11'd512;
    push(1'b1, 24'h100000, 10'd512);
    push(1'b1, 24'h100200, 10'd512);
    push(1'b1, 24'h100400, 10'd276);
    repeat (3) serve(0, 1'b0);
    chk_status("after_abort", 2'd0, 2'd2, 1'b1, 16'd1, 16'd1);
    // bypass: write completion coincides with rd_frame_start while a frame is pending
    pulse(1'b1, 1'b0);
    push(1'b1, 24'h000000, 10'd512);
    push(1'b1, 24'h000200, 10'd512);
    push(1'b1, 24'h000400, 10'd276);
    serve(0, 1'b0);
    serve(0, 1'b0);
    serve(0, 1'b1);
    chk_status("bypass", 2'd1, 2'd0, 1'b1, 16'd1, 16'd1);
    // reset while a command is pending
    pulse(1'b1, 1'b0);
    push(1'b1, 24'h100000, 10'd512);
    get_cmd(ok, e);
    rst = 1'b1;
    @(negedge clk);
    chk("rstcmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rstcmd_addr", 32'(bus.cmd_addr), 32'd0);
    chk("rstcmd_len", 32'(bus.cmd_len), 32'd0);
    chk_status("rstcmd", 2'd0, 2'd0, 1'b0, 16'd0, 16'd0);
    rst = 1'b0;
    bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_valid", 32'(bus.cmd_valid), 32'd0);
    chk("late_done_wr_buf", 32'(wr_buf_idx), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_buf_arbiter.md
Name: fb_buf_arbiter

Overview:
- Parametrised frame-buffer manager and SDRAM command arbiter between the camera write FIFO and the HDMI read FIFO.
- Generalises fixed ping-pong with one write and one read region to NUM_BUF = 2 (ping-pong) or 3 (triple-buffer) frame buffers, with per-frame length, partial last bursts and frame-abort handling.
- Issues one burst command at a time to the SDRAM controller.
- Runs in the SDRAM reference clock domain. Frame-start pulses are already synchronised into this domain.

Parameters:
- ADDR_W, 24, SDRAM word-address width.
- LEN_W, 10, burst-length field width.
- BURST_LEN, 512, nominal burst length in words; must be ≤ 2^LEN_W − 1.
- FRAME_SIZE, 1024000, words per frame (1280×800).
- NUM_BUF, 3, number of frame buffers; only 2 or 3 are legal.
- BUF_STRIDE, 24'h100000, address distance between buffer bases. Buffer i base = i×BUF_STRIDE.

Ports:
- clk  in  1  SDRAM reference clock.
- rst  in  1  synchronous active-high reset.
- wr_frame_start  in  1  pulse: camera frame begins.
- rd_frame_start  in  1  pulse: display frame begins.
- wr_fifo_level  in  LEN_W+1  words waiting in the write FIFO.
- rd_fifo_room  in  LEN_W+1  free words in the read FIFO.
- cmd_valid  out  1  burst command pending.
- cmd_ready  in  1  controller accepts the command.
- cmd_write  out  1  1 = write burst, 0 = read burst.
- cmd_addr  out  ADDR_W  burst start address.
- cmd_len  out  LEN_W  burst length in words.
- cmd_done  in  1  pulse: the accepted burst has finished.
- wr_buf_idx  out  2  buffer currently being written.
- rd_buf_idx  out  2  buffer currently being displayed.
- rd_frame_valid  out  1  at least one complete frame is available.
- drop_cnt  out  16  frames overwritten without ever being displayed (saturating).
- abort_cnt  out  16  write frames aborted by an early wr_frame_start (saturating).

Behaviour:
- Reset (synchronous, rst=1):
  - Outputs: cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_len=0, wr_buf_idx=0, rd_buf_idx=0, rd_frame_valid=0, counters=0.
  - Internal: wr_off=0, rd_off=0, wr_active=0, rd_active=0, new_valid=0, latest=0.
  - Reset mid-burst drops cmd_valid on the next edge; a cmd_done pulse arriving after reset is ignored.
- FSM states: IDLE, CMD, WAIT.
  - IDLE: arbitrate. On a grant, load the command fields, set cmd_valid, go to CMD.
  - CMD: hold cmd_valid and all cmd_* fields stable until cmd_ready=1; then clear cmd_valid and go to WAIT.
  - WAIT: on cmd_done, advance the offset of the winning side by cmd_len, then go to IDLE.
  - Latency: at most 1 cycle from eligibility in IDLE to cmd_valid.
- Eligibility:
  - Write side: wr_active=1 and wr_fifo_level ≥ min(BURST_LEN, FRAME_SIZE−wr_off).
  - Read side: rd_active=1 and rd_fifo_room ≥ min(BURST_LEN, FRAME_SIZE−rd_off).
- Arbitration: if only one side is eligible, grant it. If both are eligible, grant the side not granted last time (round-robin). After reset the first tie goes to write.
- Command fields:
  - cmd_len = min(BURST_LEN, FRAME_SIZE−off), so the last burst of a frame may be short.
  - cmd_addr = buf_idx×BUF_STRIDE + off.
- wr_frame_start:
  - Sets wr_active=1 and wr_off=0.
  - If it arrives while wr_active=1 with wr_off<FRAME_SIZE: increment abort_cnt and restart the same wr_buf_idx. That frame is not marked complete.
  - If it arrives in CMD/WAIT with a write burst outstanding: the burst completes to its old address, but the offset advance is discarded.
- Write complete (wr_off reaches FRAME_SIZE):
  - wr_active=0, latest=wr_buf_idx, rd_frame_valid=1.
  - If new_valid was already 1, increment drop_cnt. Then set new_valid=1.
  - NUM_BUF=2: wr_buf_idx toggles.
  - NUM_BUF=3: wr_buf_idx = the index that is neither rd_buf_idx nor the just-completed buffer.
- rd_frame_start:
  - If new_valid=1: rd_buf_idx=latest and new_valid=0; otherwise the current buffer is repeated.
  - If rd_frame_valid=1: rd_active=1 and rd_off=0. If rd_frame_valid=0: ignored.
  - A read burst outstanding at this point behaves the same as the write case: it finishes, but its offset advance is discarded.
- Read complete (rd_off reaches FRAME_SIZE): rd_active=0.
- Simultaneous write-complete and rd_frame_start in the same cycle: the reader takes the just-completed buffer (bypass), and drop_cnt is not incremented.
- Width rule: offsets are ADDR_W bits. FRAME_SIZE ≤ BUF_STRIDE is a parameter constraint, so the address add never carries into the next buffer.

Decomposition:
- Package fb_pkg holds: FSM state enum, buffer-index type, and the next_wr_buf() function for triple-buffer selection.
- Natural sub-module: fb_side_ctr, instantiated once for write and once for read. It holds the offset counter, active flag, remaining-length computation and eligibility compare.

Test Plan:
All scenarios use FRAME_SIZE=1300, BURST_LEN=512 unless stated.
- Single frame: wr_frame_start, wr_fifo_level=512 held, cmd_ready/cmd_done auto-responding -> write bursts at buffer 0 with addr/len 0/512, 512/512, 1024/276; then rd_frame_valid=1 and wr_buf_idx=1.
- Contention, NUM_BUF=3, both sides eligible continuously -> cmd_write alternates 1,0,1,0. Read addresses start at latest×0x100000.
- Stall: cmd_ready held low for 20 cycles -> cmd_valid, cmd_addr and cmd_len stay stable for all 20 cycles; the offset advances only after cmd_done.
- Overwrite: NUM_BUF=3, two write frames complete with no rd_frame_start -> drop_cnt=1; the next rd_frame_start selects the second frame's buffer.
- Abort: wr_frame_start reissued at wr_off=512 -> abort_cnt=1; the next write burst uses addr = wr_buf_idx×0x100000 + 0; latest is unchanged.
- Bypass and reset: write-complete coincides with rd_frame_start -> rd_buf_idx = the completed buffer and drop_cnt=0. Then rst pulsed during CMD -> cmd_valid=0 and all indices/counters = 0 on the next cycle.
